alu_fn_issuer: RTL and testbench

ALU_FN_ISSUER -- requirements
Module: alu_fn_issuer

---
 rtl/alu_fn_issuer_pkg.sv | 18 +
 rtl/alu_fn_issuer_if.sv | 31 +++
 rtl/alu_fn_issuer_fn_prio_enc8to3.sv | 29 ++
 rtl/alu_fn_issuer.sv | 79 +++++++
 tb/tb_alu_fn_issuer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_fn_issuer_pkg.sv
// Shared types and constants for the ALU function-code issuer.
// Holds the code width, the default buffer depth and the eight code values.
// Imported by the interface, the priority encoder and the top.
package alu_fn_pkg;

  localparam int FN_W          = 3;
  localparam int DEPTH_DEFAULT = 4;

  localparam logic [FN_W-1:0] FN_0 = 3'd0;
  localparam logic [FN_W-1:0] FN_1 = 3'd1;
  localparam logic [FN_W-1:0] FN_2 = 3'd2;
  localparam logic [FN_W-1:0] FN_3 = 3'd3;
  localparam logic [FN_W-1:0] FN_4 = 3'd4;
  localparam logic [FN_W-1:0] FN_5 = 3'd5;
  localparam logic [FN_W-1:0] FN_6 = 3'd6;
  localparam logic [FN_W-1:0] FN_7 = 3'd7;

endpackage

// File: rtl/alu_fn_issuer_if.sv
// Request-side and decoder-side handshake bundle for the issuer.
// slave: the issuer itself; master: whoever drives requests and consumes codes.
// count is sized to hold 0..DEPTH inclusive.
interface alu_fn_issuer_if
  import alu_fn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);

  logic [7:0]               req;
  logic                     req_valid;
  logic                     req_ready;
  logic                     f2;
  logic                     f1;
  logic                     f0;
  logic                     f_valid;
  logic                     f_ready;
  logic                     err_zero;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  req, req_valid, f_ready,
    output req_ready, f2, f1, f0, f_valid, err_zero, count
  );

  modport master (
    output req, req_valid, f_ready,
    input  req_ready, f2, f1, f0, f_valid, err_zero, count
  );

endinterface

// File: rtl/alu_fn_issuer_fn_prio_enc8to3.sv
// Purpose: 8-to-3 priority encoder, bit 7 wins; flags an all-zero request.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the result is used.
module fn_prio_enc8to3
  import alu_fn_pkg::*;
(
  input  logic [7:0]      req,
  output logic [FN_W-1:0] code,
  output logic            zero
);

  // Highest set bit selects the function code; all-zero falls through to FN_0.
  always_comb begin
    code = FN_0;
    casez (req)
      8'b1???????: code = FN_7;
      8'b01??????: code = FN_6;
      8'b001?????: code = FN_5;
      8'b0001????: code = FN_4;
      8'b00001???: code = FN_3;
      8'b000001??: code = FN_2;
      8'b0000001?: code = FN_1;
      default:     code = FN_0;
    endcase
  end

  assign zero = (req == 8'h00);

endmodule

// File: rtl/alu_fn_issuer.sv
// Purpose: encodes request lines to 3-bit ALU function codes and queues them in a DEPTH-deep FIFO.
// Latency: a code accepted into an empty FIFO is visible on f2..f0 the cycle after the accept edge.
// Backpressure: req_ready drops only when the FIFO is full; it never looks at f_ready.
module alu_fn_issuer
  import alu_fn_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  alu_fn_issuer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] cnt;
  logic             errZero;

  logic [FN_W-1:0]  encCode;
  logic             encZero;
  logic [FN_W-1:0]  head;
  logic             accept;
  logic             push;
  logic             pop;

  fn_prio_enc8to3 uEnc (
    .req  (bus.req),
    .code (encCode),
    .zero (encZero)
  );

  // An all-zero request is still accepted (it consumes the handshake) but stores nothing.
  assign accept = bus.req_valid && bus.req_ready;
  assign push   = accept && !encZero;
  assign pop    = bus.f_valid && bus.f_ready;

  // Storage is left unreset: entries are only ever read when count says they are live.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= encCode;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // One-cycle flag for an accepted request that named no function.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) errZero <= 1'b0;
    else        errZero <= accept && encZero;
  end

  // Head is forced to zero when empty so the decoder never sees a stale entry.
  assign head          = (cnt != '0) ? mem[rdPtr] : FN_0;
  assign bus.f2        = head[2];
  assign bus.f1        = head[1];
  assign bus.f0        = head[0];
  assign bus.f_valid   = (cnt != '0);
  assign bus.req_ready = (cnt < CNT_W'(DEPTH));
  assign bus.err_zero  = errZero;
  assign bus.count     = cnt;

endmodule

// File: tb/tb_alu_fn_issuer.sv
// Directed bench for alu_fn_issuer with DEPTH=4.
// Inputs change 1ns after the rising edge; outputs are checked in the same window.
// Each task covers one behaviour and counts its own comparisons.
module tb_alu_fn_issuer;
  import alu_fn_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  alu_fn_issuer_if #(.DEPTH(DEPTH)) bus ();

  alu_fn_issuer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2:0] fOut;
  assign fOut = {bus.f2, bus.f1, bus.f0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req       = 8'h00;
    bus.req_valid = 1'b0;
    bus.f_ready   = 1'b0;
    #3;
    vecs++; if (bus.f_valid !== 1'b0) begin errs++; $display("FAIL reset_fvalid: got %0b want 0", bus.f_valid); end
    vecs++; if (bus.count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    vecs++; if (bus.req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %0b want 1", bus.req_ready); end
    vecs++; if (fOut !== 3'b000) begin errs++; $display("FAIL reset_f: got %03b want 000", fOut); end
    vecs++; if (bus.err_zero !== 1'b0) begin errs++; $display("FAIL reset_errzero: got %0b want 0", bus.err_zero); end
    step();
    step();
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [2:0] exp [3];
    exp[0] = 3'b000; exp[1] = 3'b111; exp[2] = 3'b101;
    bus.f_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'h01;
    step();
    vecs++; if (bus.f_valid !== 1'b1 || fOut !== 3'b000) begin errs++; $display("FAIL basic_latency: got v=%0b f=%03b want v=1 f=000", bus.f_valid, fOut); end
    bus.req = 8'h80; step();
    bus.req = 8'h24; step();
    bus.req_valid = 1'b0; bus.req = 8'h00;
    vecs++; if (bus.count !== 3'd3) begin errs++; $display("FAIL basic_count: got %0d want 3", bus.count); end
    step();
    vecs++; if (fOut !== 3'b000) begin errs++; $display("FAIL basic_stall_head: got %03b want 000", fOut); end
    bus.f_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (bus.f_valid !== 1'b1 || fOut !== exp[k]) begin
        errs++; $display("FAIL basic_issue%0d: got v=%0b f=%03b want v=1 f=%03b", k, bus.f_valid, fOut, exp[k]);
      end
      step();
    end
    vecs++; if (bus.f_valid !== 1'b0 || fOut !== 3'b000 || bus.count !== 3'd0) begin errs++; $display("FAIL basic_drained: got v=%0b f=%03b c=%0d want 0/000/0", bus.f_valid, fOut, bus.count); end
    bus.f_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] reqs [5];
    reqs[0] = 8'h02; reqs[1] = 8'h04; reqs[2] = 8'h08; reqs[3] = 8'h10; reqs[4] = 8'h20;
    bus.f_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req = reqs[i];
      vecs++;
      if (bus.req_ready !== (i < 4)) begin errs++; $display("FAIL full_ready%0d: got %0b want %0b", i, bus.req_ready, (i < 4)); end
      step();
    end
    bus.req_valid = 1'b0; bus.req = 8'h00;
    vecs++; if (bus.count !== 3'd4 || bus.req_ready !== 1'b0) begin errs++; $display("FAIL full_hold: got c=%0d r=%0b want c=4 r=0", bus.count, bus.req_ready); end
    vecs++; if (fOut !== 3'd1) begin errs++; $display("FAIL full_head: got %0d want 1", fOut); end
  endtask

  // Continues from a full FIFO holding 1,2,3,4; table codes are hand-derived.
  task automatic test_wrap();
    logic [7:0] reqTbl [8];
    logic [2:0] codeTbl [8];
    logic [2:0] q [$];
    int idx;
    int cyc;
    logic acc;
    logic pp;
    reqTbl  = '{8'h40, 8'hC0, 8'h03, 8'h01, 8'h18, 8'h2A, 8'h07, 8'h0C};
    codeTbl = '{3'd6,  3'd7,  3'd1,  3'd0,  3'd4,  3'd5,  3'd2,  3'd3};
    q = '{3'd1, 3'd2, 3'd3, 3'd4};
    idx = 0;
    cyc = 0;
    bus.f_ready = 1'b1;
    while ((idx < 8 || q.size() != 0) && cyc < 40) begin
      bus.req_valid = (idx < 8);
      bus.req = (idx < 8) ? reqTbl[idx] : 8'h00;
      vecs++; if (bus.req_ready !== (q.size() < DEPTH)) begin errs++; $display("FAIL wrap_ready c%0d: got %0b want %0b", cyc, bus.req_ready, (q.size() < DEPTH)); end
      vecs++; if (bus.count !== 3'(q.size())) begin errs++; $display("FAIL wrap_count c%0d: got %0d want %0d", cyc, bus.count, q.size()); end
      vecs++; if (bus.f_valid !== (q.size() != 0)) begin errs++; $display("FAIL wrap_fvalid c%0d: got %0b want %0b", cyc, bus.f_valid, (q.size() != 0)); end
      if (q.size() != 0) begin
        vecs++; if (fOut !== q[0]) begin errs++; $display("FAIL wrap_head c%0d: got %0d want %0d", cyc, fOut, q[0]); end
      end
      acc = bus.req_valid && (q.size() < DEPTH);
      pp  = (q.size() != 0);
      step();
      if (pp) void'(q.pop_front());
      if (acc) begin
        q.push_back(codeTbl[idx]);
        idx++;
      end
      cyc++;
    end
    vecs++; if (idx != 8 || q.size() != 0) begin errs++; $display("FAIL wrap_timeout: got idx=%0d left=%0d want 8/0", idx, q.size()); end
    bus.req_valid = 1'b0; bus.req = 8'h00; bus.f_ready = 1'b0;
  endtask

  task automatic test_zero();
    bus.f_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'h10;
    step();
    bus.req = 8'h00;
    vecs++; if (bus.err_zero !== 1'b0) begin errs++; $display("FAIL zero_pre: got %0b want 0", bus.err_zero); end
    step();
    bus.req_valid = 1'b0;
    vecs++; if (bus.err_zero !== 1'b1) begin errs++; $display("FAIL zero_pulse: got %0b want 1", bus.err_zero); end
    vecs++; if (bus.count !== 3'd1 || fOut !== 3'd4) begin errs++; $display("FAIL zero_nopush: got c=%0d f=%0d want c=1 f=4", bus.count, fOut); end
    step();
    vecs++; if (bus.err_zero !== 1'b0) begin errs++; $display("FAIL zero_width: got %0b want 0", bus.err_zero); end
    bus.f_ready = 1'b1;
    step();
    bus.f_ready = 1'b0;
    vecs++; if (bus.count !== 3'd0 || bus.f_valid !== 1'b0) begin errs++; $display("FAIL zero_drain: got c=%0d v=%0b want 0/0", bus.count, bus.f_valid); end
  endtask

  task automatic test_simul();
    bus.f_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'h01; step();
    bus.req = 8'h08; step();
    vecs++; if (bus.count !== 3'd2 || fOut !== 3'd0) begin errs++; $display("FAIL simul_setup: got c=%0d f=%0d want 2/0", bus.count, fOut); end
    bus.req = 8'h80; bus.f_ready = 1'b1;
    step();
    bus.req_valid = 1'b0; bus.req = 8'h00;
    vecs++; if (bus.count !== 3'd2 || fOut !== 3'd3) begin errs++; $display("FAIL simul_pushpop: got c=%0d f=%0d want 2/3", bus.count, fOut); end
    step();
    vecs++; if (bus.count !== 3'd1 || fOut !== 3'd7) begin errs++; $display("FAIL simul_next: got c=%0d f=%0d want 1/7", bus.count, fOut); end
    step();
    bus.f_ready = 1'b0;
    vecs++; if (bus.f_valid !== 1'b0 || fOut !== 3'd0) begin errs++; $display("FAIL simul_empty: got v=%0b f=%0d want 0/0", bus.f_valid, fOut); end
  endtask

  task automatic test_async_reset();
    bus.f_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'h02; step();
    bus.req = 8'h04; step();
    bus.req = 8'h08; step();
    bus.req_valid = 1'b0; bus.req = 8'h00;
    vecs++; if (bus.count !== 3'd3) begin errs++; $display("FAIL arst_setup: got %0d want 3", bus.count); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (bus.f_valid !== 1'b0 || bus.count !== 3'd0) begin errs++; $display("FAIL arst_immediate: got v=%0b c=%0d want 0/0", bus.f_valid, bus.count); end
    vecs++; if (bus.req_ready !== 1'b1 || fOut !== 3'd0) begin errs++; $display("FAIL arst_outputs: got r=%0b f=%0d want 1/0", bus.req_ready, fOut); end
    step();
    #2 rst_n = 1'b1;
    bus.f_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (bus.f_valid !== 1'b0) begin errs++; $display("FAIL arst_noissue%0d: got %0b want 0", k, bus.f_valid); end
    end
    bus.f_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req = 8'h40;
    step();
    bus.req_valid = 1'b0; bus.req = 8'h00;
    vecs++; if (bus.f_valid !== 1'b1 || fOut !== 3'd6 || bus.count !== 3'd1) begin errs++; $display("FAIL arst_newpush: got v=%0b f=%0d c=%0d want 1/6/1", bus.f_valid, fOut, bus.count); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_zero();
    test_simul();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
